// File: rtl/mem_burst_ctrl.sv
// Two-requester round-robin burst sequencer in front of a single-port memory.
// Each granted burst is issued as one single-beat memory access per cycle.
module mem_burst_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [LEN_W-1:0]  len_a,
  input  logic [LEN_W-1:0]  len_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic              done_a,
  output logic              done_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_burst_enable,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                owner;       // 0 = A, 1 = B
  logic                last_owner;
  logic                owner_nxt;
  logic [ADDR_W-1:0]   base;
  logic [LEN_W-1:0]    beat;
  logic [LEN_W-1:0]    limit;
  logic                grant_valid;
  logic                grant_b;
  logic                last_beat;

  // Ties go to whichever requester did not own the previous burst.
  assign grant_valid = req_a | req_b;
  assign grant_b     = req_b & (~req_a | ~last_owner);
  assign last_beat   = (beat == limit);
  assign owner_nxt   = (state == IDLE) ? grant_b : owner;

  assign rdata            = mem_rdata;
  assign mem_burst_enable = 1'b0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_valid) state_nxt = (grant_b ? we_b : we_a) ? WRITE : READ;
      end
      WRITE, READ: begin
        if (last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= 1'b0;
      last_owner <= 1'b1;
      base       <= '0;
      beat       <= '0;
      limit      <= '0;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      rvalid_a   <= 1'b0;
      rvalid_b   <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (grant_valid) begin
          owner      <= grant_b;
          last_owner <= grant_b;
          base       <= grant_b ? addr_b : addr_a;
          limit      <= grant_b ? len_b  : len_a;
          beat       <= '0;
        end
      end else begin
        beat <= last_beat ? '0 : beat + LEN_W'(1);
      end
      gnt_a    <= (state_nxt != IDLE) && !owner_nxt;
      gnt_b    <= (state_nxt != IDLE) &&  owner_nxt;
      // Memory answers one edge after the read beat, so the strobe carries
      // the owner of the beat, not the owner of the following cycle.
      rvalid_a <= (state == READ) && !owner;
      rvalid_b <= (state == READ) &&  owner;
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    ack_a     = 1'b0;
    ack_b     = 1'b0;
    done_a    = 1'b0;
    done_b    = 1'b0;
    case (state)
      WRITE: begin
        mem_addr  = base + ADDR_W'(beat);
        mem_wdata = owner ? wdata_b : wdata_a;
        mem_we    = 1'b1;
        ack_a     = !owner;
        ack_b     =  owner;
        done_a    = last_beat && !owner;
        done_b    = last_beat &&  owner;
      end
      READ: begin
        mem_addr  = base + ADDR_W'(beat);
        done_a    = last_beat && !owner;
        done_b    = last_beat &&  owner;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl: behavioural memory, queued requesters
// and a transaction-level reference model compared every cycle.
module tb_mem_burst_ctrl;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int LW = 4;

  typedef struct packed {
    logic               we;
    logic [AW-1:0]      addr;
    logic [LW-1:0]      len;
    logic [15:0][DW-1:0] data;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_a, req_b, we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [LW-1:0] len_a, len_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, gnt_b, ack_a, ack_b, done_a, done_b, rvalid_a, rvalid_b;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_burst_enable;

  mem_burst_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .len_a(len_a), .len_b(len_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .ack_a(ack_a), .ack_b(ack_b),
    .done_a(done_a), .done_b(done_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_burst_enable(mem_burst_enable), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 512x32 single-port memory with registered read data
  logic [DW-1:0] mem [0:511];
  bit            init_done = 1'b0;

  function automatic logic [DW-1:0] init_val(int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one burst in flight, beat index, read-return slot
  logic [DW-1:0] model_mem [0:511];
  bit            m_busy, m_owner, m_last;
  int            m_beat;
  txn_t          m_txn;
  bit            rv_valid, rv_owner;
  logic [DW-1:0] rv_data;

  // Requesters
  txn_t q_a[$];
  txn_t q_b[$];
  bit   act [2];
  int   idx [2];
  int   gap_cnt [2];
  txn_t cur [2];
  int   max_gap = 0;

  // Observation log
  int cnt_rv [2];
  int log_owner[$];
  int log_cyc[$];
  bit prev_gnt [2];

  task automatic sample_check();
    logic [9:0]    ectl, actl;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    logic          eg_a, eg_b, eack_a, eack_b, edn_a, edn_b, ewe;
    eg_a = 0; eg_b = 0; eack_a = 0; eack_b = 0; edn_a = 0; edn_b = 0; ewe = 0;
    ea = '0; ewd = '0;
    if (m_busy) begin
      ea   = m_txn.addr + AW'(m_beat);
      ewe  = m_txn.we;
      ewd  = m_txn.we ? m_txn.data[m_beat] : '0;
      eg_a = !m_owner;
      eg_b = m_owner;
      eack_a = m_txn.we && !m_owner;
      eack_b = m_txn.we && m_owner;
      edn_a  = (m_beat == int'(m_txn.len)) && !m_owner;
      edn_b  = (m_beat == int'(m_txn.len)) && m_owner;
    end
    ectl = {eg_a, eg_b, eack_a, eack_b, edn_a, edn_b, ewe,
            rv_valid && !rv_owner, rv_valid && rv_owner, 1'b0};
    actl = {gnt_a, gnt_b, ack_a, ack_b, done_a, done_b, mem_we,
            rvalid_a, rvalid_b, mem_burst_enable};
    n_tests++;
    if (actl !== ectl) begin
      n_fail++;
      $display("FAIL ctl cyc=%0d got gnt/ack/done/we/rv/be=%b expected %b", cyc, actl, ectl);
    end
    n_tests++;
    if (mem_addr !== ea) begin
      n_fail++;
      $display("FAIL mem_addr cyc=%0d got %0d expected %0d", cyc, mem_addr, ea);
    end
    if (!m_busy || m_txn.we) begin
      n_tests++;
      if (mem_wdata !== ewd) begin
        n_fail++;
        $display("FAIL mem_wdata cyc=%0d got %h expected %h", cyc, mem_wdata, ewd);
      end
    end
    if (rv_valid) begin
      n_tests++;
      if (rdata !== rv_data) begin
        n_fail++;
        $display("FAIL rdata cyc=%0d got %h expected %h", cyc, rdata, rv_data);
      end
    end
    if (gnt_a && !prev_gnt[0]) begin log_owner.push_back(0); log_cyc.push_back(cyc); end
    if (gnt_b && !prev_gnt[1]) begin log_owner.push_back(1); log_cyc.push_back(cyc); end
    prev_gnt[0] = gnt_a;
    prev_gnt[1] = gnt_b;
    if (rvalid_a) cnt_rv[0]++;
    if (rvalid_b) cnt_rv[1]++;
  endtask

  task automatic model_update();
    logic [AW-1:0] a;
    bit            nv;
    bit            o;
    nv = 0;
    if (m_busy) begin
      a = m_txn.addr + AW'(m_beat);
      if (m_txn.we) begin
        model_mem[a] = m_txn.data[m_beat];
      end else begin
        nv       = 1;
        rv_owner = m_owner;
        rv_data  = model_mem[a];
      end
      if (m_beat == int'(m_txn.len)) m_busy = 0;
      else                          m_beat++;
    end else if (req_a || req_b) begin
      o       = (req_a && req_b) ? !m_last : req_b;
      m_owner = o;
      m_last  = o;
      m_txn   = cur[o];
      m_beat  = 0;
      m_busy  = 1;
    end
    rv_valid = nv;
  endtask

  task automatic pop_txn(input int x, output txn_t t, output bit ok);
    ok = 0;
    if (x == 0 && q_a.size() > 0) begin t = q_a.pop_front(); ok = 1; end
    if (x == 1 && q_b.size() > 0) begin t = q_b.pop_front(); ok = 1; end
  endtask

  task automatic requester_update();
    bit   dn, ak, ok;
    txn_t t;
    for (int x = 0; x < 2; x++) begin
      dn = (x == 0) ? done_a : done_b;
      ak = (x == 0) ? ack_a  : ack_b;
      if (act[x] && dn) begin
        pop_txn(x, t, ok);
        if (ok && max_gap == 0) begin
          cur[x] = t; idx[x] = 0;
        end else begin
          if (ok) begin
            if (x == 0) q_a.push_front(t);
            else        q_b.push_front(t);
          end
          act[x]     = 0;
          gap_cnt[x] = (max_gap == 0) ? 1 : int'($urandom_range(1, max_gap));
        end
      end else if (act[x] && ak) begin
        idx[x]++;
      end else if (!act[x]) begin
        if (gap_cnt[x] > 1) begin
          gap_cnt[x]--;
        end else begin
          pop_txn(x, t, ok);
          if (ok) begin cur[x] = t; idx[x] = 0; act[x] = 1; end
        end
      end
    end
  endtask

  task automatic apply_inputs();
    req_a   = act[0];
    we_a    = act[0] ? cur[0].we   : 1'b0;
    addr_a  = act[0] ? cur[0].addr : '0;
    len_a   = act[0] ? cur[0].len  : '0;
    wdata_a = act[0] ? cur[0].data[idx[0] % 16] : '0;
    req_b   = act[1];
    we_b    = act[1] ? cur[1].we   : 1'b0;
    addr_b  = act[1] ? cur[1].addr : '0;
    len_b   = act[1] ? cur[1].len  : '0;
    wdata_b = act[1] ? cur[1].data[idx[1] % 16] : '0;
  endtask

  task automatic step(input bit cut_at_beat2, output bit cut);
    cut = 0;
    @(negedge clk);
    sample_check();
    if (cut_at_beat2 && m_busy && m_beat == 2) begin
      rst_n = 1'b0;
      cut   = 1;
      return;
    end
    model_update();
    requester_update();
    @(posedge clk);
    #1;
    apply_inputs();
  endtask

  task automatic run_drain(input int budget);
    int n;
    bit c;
    n = 0;
    while ((q_a.size() > 0 || q_b.size() > 0 || act[0] || act[1] || m_busy || rv_valid)
           && n < budget) begin
      step(1'b0, c);
      n++;
    end
    n_tests++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL drain_timeout got %0d cycles expected under %0d", n, budget);
    end
  endtask

  task automatic reset_model();
    m_busy = 0; m_last = 1; m_beat = 0; rv_valid = 0;
    q_a.delete(); q_b.delete();
    for (int x = 0; x < 2; x++) begin
      act[x] = 0; idx[x] = 0; gap_cnt[x] = 0; prev_gnt[x] = 0; cnt_rv[x] = 0;
    end
    log_owner.delete(); log_cyc.delete();
    apply_inputs();
  endtask

  task automatic check_outputs_zero(input string name);
    logic [9:0]    ctl;
    ctl = {gnt_a, gnt_b, ack_a, ack_b, done_a, done_b, mem_we, rvalid_a, rvalid_b,
           mem_burst_enable};
    n_tests++;
    if (ctl !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL %s ctl=%b addr=%0d wdata=%h expected all zero", name, ctl, mem_addr, mem_wdata);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    reset_model();
    #1;
    check_outputs_zero("reset_outputs");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic txn_t make_txn(bit we, int addr, int len);
    txn_t t;
    t.we   = we;
    t.addr = AW'(addr);
    t.len  = LW'(len);
    for (int i = 0; i < 16; i++) t.data[i] = $urandom();
    return t;
  endfunction

  task automatic check_mem(input string name, input int a, input logic [DW-1:0] exp);
    n_tests++;
    if (mem[a] !== exp) begin
      n_fail++;
      $display("FAIL %s mem[%0d] got %h expected %h", name, a, mem[a], exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    run_drain(5);
  endtask

  task automatic test_write_a();
    txn_t t;
    t = make_txn(1, 10, 3);
    for (int i = 0; i < 4; i++) t.data[i] = DW'(32'hA0 + i);
    log_owner.delete(); log_cyc.delete();
    q_a.push_back(t);
    run_drain(50);
    check_int("write_a_first_owner", (log_owner.size() > 0) ? log_owner[0] : -1, 0);
    for (int i = 0; i < 4; i++) check_mem("write_a", 10 + i, DW'(32'hA0 + i));
  endtask

  task automatic test_read_a();
    cnt_rv[0] = 0; cnt_rv[1] = 0;
    q_a.push_back(make_txn(0, 10, 3));
    run_drain(50);
    check_int("read_a_rvalid_a_count", cnt_rv[0], 4);
    check_int("read_a_rvalid_b_count", cnt_rv[1], 0);
  endtask

  task automatic test_alternate();
    do_reset();
    max_gap = 0;
    for (int i = 0; i < 4; i++) begin
      q_a.push_back(make_txn(1, 200 + i, 0));
      q_b.push_back(make_txn(1, 300 + i, 0));
    end
    run_drain(100);
    check_int("alternate_grant_count", log_owner.size(), 8);
    for (int i = 0; i < 8 && i < log_owner.size(); i++)
      check_int("alternate_owner", log_owner[i], i % 2);
  endtask

  task automatic test_wrap();
    txn_t t;
    max_gap = 1;
    t = make_txn(1, 510, 3);
    q_b.push_back(t);
    q_b.push_back(make_txn(0, 510, 3));
    run_drain(60);
    check_mem("wrap", 510, t.data[0]);
    check_mem("wrap", 511, t.data[1]);
    check_mem("wrap", 0,   t.data[2]);
    check_mem("wrap", 1,   t.data[3]);
  endtask

  task automatic test_back_to_back();
    bit c;
    log_owner.delete(); log_cyc.delete();
    q_a.push_back(make_txn(1, $urandom_range(0, 511), 15));
    step(1'b0, c);
    step(1'b0, c);
    q_b.push_back(make_txn(0, $urandom_range(0, 511), 2));
    run_drain(80);
    if (log_owner.size() >= 2) begin
      check_int("b2b_first_owner", log_owner[0], 0);
      check_int("b2b_second_owner", log_owner[1], 1);
      check_int("b2b_gap_cycles", log_cyc[1] - log_cyc[0], 17);
    end else begin
      check_int("b2b_grant_count", log_owner.size(), 2);
    end
  endtask

  task automatic test_reset_mid();
    txn_t t;
    bit   c;
    int   n;
    t = make_txn(1, 100, 7);
    q_a.push_back(t);
    c = 0; n = 0;
    while (!c && n < 40) begin step(1'b1, c); n++; end
    check_int("reset_mid_reached_beat2", int'(c), 1);
    if (!c) rst_n = 1'b0;
    reset_model();
    #1;
    check_outputs_zero("reset_mid_outputs");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_mem("reset_mid_beat0", 100, t.data[0]);
    check_mem("reset_mid_beat1", 101, t.data[1]);
    for (int i = 2; i < 8; i++) check_mem("reset_mid_untouched", 100 + i, model_mem[100 + i]);
    q_b.push_back(make_txn(0, 101, 0));
    run_drain(20);
    check_int("reset_mid_b_granted", (log_owner.size() > 0) ? log_owner[0] : -1, 1);
  endtask

  task automatic test_random();
    int bad;
    max_gap = 2;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0)
        q_a.push_back(make_txn($urandom_range(0, 1), $urandom_range(0, 511), $urandom_range(0, 15)));
      else
        q_b.push_back(make_txn($urandom_range(0, 1), $urandom_range(0, 511), $urandom_range(0, 15)));
    end
    run_drain(40 * 20 + 100);
    bad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== model_mem[i]) bad++;
    check_int("random_mem_image_mismatches", bad, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 512; i++) model_mem[i] = init_val(i);
    reset_model();
    @(posedge clk);
    #1;
    init_done = 1'b1;
    test_reset();
    test_write_a();
    test_read_a();
    test_alternate();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
